llkid_key_sender: RTL
=====================

// Module: llkid_key_sender
// PURPOSE
//  Initiator side of the LLKI discrete key interface. Accepts LOAD/CLEAR/STATUS commands
//  and 64-bit key words from the LLKI controller side and drives a core's TSS through the
//  llkid_* key_data/valid/ready/complete and clear_key/ack handshakes, returning one 8-bit
//  response per command. It sits between the LLKI protocol processor and one crypto core wrapper.
// PARAMETERS
//  KEY_WORDS       2    64-bit words per key load (1..15)
//  FIFO_DEPTH      4    key-word FIFO entries (power of 2, >= KEY_WORDS)
//  TIMEOUT_CYCLES  255  max cycles spent in any wait state before TIMEOUT (1..65535)
// PORTS
//  clk                  in   1   clock
//  rst_n                in   1   asynchronous active-low reset
//  cmd_valid            in   1   command present
//  cmd_ready            out  1   command accepted when cmd_valid&cmd_ready
//  cmd_op               in   2   0=LOAD 1=CLEAR 2=STATUS 3=reserved
//  kw_data              in   64  key word to FIFO
//  kw_valid             in   1   key word present
//  kw_ready             out  1   FIFO not full
//  rsp_valid            out  1   response present, held until rsp_ready
//  rsp_ready            in   1   response consumed
//  rsp_code             out  8   01 LOAD_OK 02 CLEAR_OK 03 TIMEOUT 04 NO_KEY 05 KEY_PRESENT 06 KEY_ABSENT 07 BAD_OP
//  busy                 out  1   state != IDLE or rsp_valid
//  llkid_key_data       out  64  key word to TSS
//  llkid_key_valid      out  1   key word valid
//  llkid_key_ready      in   1   TSS ready; transfer = valid&ready at rising clk
//  llkid_key_complete   in   1   TSS reports full key loaded
//  llkid_clear_key      out  1   clear request, level, held until ack or timeout
//  llkid_clear_key_ack  in   1   TSS clear acknowledge (may be 1-cycle pulse)
// BEHAVIOUR
//  Reset (rst_n=0, async): all outputs 0 except kw_ready=1; FIFO empty; state IDLE; counters 0.
//   Reset does not clear the TSS key; software issues CLEAR after reset.
//  FIFO: push on kw_valid&kw_ready; kw_ready=0 when count==FIFO_DEPTH; simultaneous push+pop
//   keeps count; ptrs wrap mod FIFO_DEPTH. Pops only in SEND on a TSS transfer.
//  cmd_ready=1 only in IDLE with rsp_valid=0. Response registered: rsp_valid rises the cycle after
//   the completing event; only one outstanding response; rsp_code stable while rsp_valid=1.
//  States: IDLE, SEND, WAIT_CMPL, CLEAR, RESP.
//  IDLE: on accepted cmd:
//   LOAD & fifo_count>=KEY_WORDS -> SEND, word_cnt=0, tmo=0; llkid_key_valid=1 next cycle with FIFO head.
//   LOAD & fifo_count<KEY_WORDS  -> RESP code 04; FIFO untouched.
//   CLEAR -> CLEAR, llkid_clear_key=1 next cycle; FIFO flushed same edge.
//   STATUS -> RESP code 05 if llkid_key_complete sampled 1 at accept edge else 06.  op 3 -> RESP 07.
//  SEND: key_valid=1, key_data=FIFO head. On transfer: pop, word_cnt++, tmo=0; if word_cnt was
//   KEY_WORDS-1 -> drop key_valid next cycle, go WAIT_CMPL; else next head presented next cycle
//   (TSS ready low after accept blocks a double-transfer). tmo increments each non-transfer cycle.
//  WAIT_CMPL: key_valid=0; sample key_complete from first cycle after last transfer;
//   key_complete=1 -> RESP 01.
//  CLEAR: clear_key=1 until llkid_clear_key_ack sampled 1 -> clear_key=0 next cycle, RESP 02.
//   Acks seen outside CLEAR are ignored.
//  Timeout: in SEND/WAIT_CMPL/CLEAR, tmo==TIMEOUT_CYCLES -> deassert key_valid/clear_key, RESP 03;
//   on SEND timeout remaining words of this key are dropped from FIFO (FIFO flushed).
//  RESP: rsp_valid=1; rsp_valid&rsp_ready -> rsp_valid=0, IDLE next cycle.
//  Ack and timeout on same cycle: ack wins (02). Complete and timeout same cycle: 01 wins.
//  kw pushes are accepted in every state, including during CLEAR flush (flush then push: count=1).
// TESTING
//  1 Push A0=0x0123456789ABCDEF, A1=0xFEDCBA9876543210; LOAD vs responder (8 wait states) ->
//    two transfers A0 then A1 in order, key_valid never high while ready low after accept, rsp 01.
//  2 Push one word, LOAD (KEY_WORDS=2) -> rsp 04 next cycle, no key_valid, FIFO count stays 1.
//  3 CLEAR with responder acking after 10 cycles -> clear_key high 10 cycles, drops, rsp 02, FIFO empty.
//  4 LOAD with ready tied 0, TIMEOUT_CYCLES=16 -> rsp 03 after 16 cycles, key_valid 0, FIFO empty.
//  5 STATUS after test 1 -> 05; after test 3 -> 06; cmd_op=3 -> 07; hold rsp_ready=0 5 cycles -> code stable, cmd_ready=0.
//  6 Assert rst_n=0 mid-SEND after first transfer -> all outputs reset immediately, kw_ready=1, next LOAD gives 04.

Source files
------------

// File: rtl/llkid_key_sender.sv
// Initiator side of the LLKI discrete key interface: buffers key words in a small FIFO,
// drives them to a core's TSS on LOAD, requests CLEAR, and reports one response per command.
module llkid_key_sender #(
  parameter int unsigned KEY_WORDS      = 2,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [63:0] kw_data,
  input  logic        kw_valid,
  output logic        kw_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_code,
  output logic        busy,
  output logic [63:0] llkid_key_data,
  output logic        llkid_key_valid,
  input  logic        llkid_key_ready,
  input  logic        llkid_key_complete,
  output logic        llkid_clear_key,
  input  logic        llkid_clear_key_ack
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_CMPL, CLEAR, RESP} state_t;

  localparam logic [7:0] C_LOAD_OK = 8'h01, C_CLEAR_OK = 8'h02, C_TIMEOUT = 8'h03,
                         C_NO_KEY  = 8'h04, C_PRESENT  = 8'h05, C_ABSENT  = 8'h06,
                         C_BAD_OP  = 8'h07;

  state_t         state, state_nxt;
  logic [63:0]    mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic [15:0]    tmo, tmo_nxt;
  logic [3:0]     word_cnt, wc_nxt;
  logic [7:0]     code_nxt;
  logic           started, flush, push, pop, xfer, cmd_fire;

  assign push     = kw_valid & kw_ready;
  assign xfer     = llkid_key_valid & llkid_key_ready;
  assign pop      = (state == SEND) & xfer;
  assign cmd_fire = cmd_valid & cmd_ready;
  assign kw_ready = (count != CW'(FIFO_DEPTH));

  // FIFO storage needs no reset; emptiness is carried by count/pointers.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= kw_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // a push on the flush edge survives as the only entry
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= wr_ptr;
      count  <= CW'(push);
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tmo      <= '0;
      word_cnt <= '0;
      rsp_code <= '0;
      started  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tmo      <= tmo_nxt;
      word_cnt <= wc_nxt;
      rsp_code <= code_nxt;
      started  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    tmo_nxt   = tmo;
    wc_nxt    = word_cnt;
    code_nxt  = rsp_code;
    flush     = 1'b0;
    unique case (state)
      IDLE: if (cmd_fire) begin
        tmo_nxt = '0;
        unique case (cmd_op)
          2'd0: if (count >= CW'(KEY_WORDS)) begin
                  state_nxt = SEND;
                  wc_nxt    = '0;
                end else begin
                  state_nxt = RESP;
                  code_nxt  = C_NO_KEY;
                end
          2'd1: begin
                  state_nxt = CLEAR;
                  flush     = 1'b1;
                end
          2'd2: begin
                  state_nxt = RESP;
                  code_nxt  = llkid_key_complete ? C_PRESENT : C_ABSENT;
                end
          default: begin
                  state_nxt = RESP;
                  code_nxt  = C_BAD_OP;
                end
        endcase
      end
      SEND: if (xfer) begin
        wc_nxt  = word_cnt + 4'd1;
        tmo_nxt = '0;
        if (word_cnt == 4'(KEY_WORDS - 1)) state_nxt = WAIT_CMPL;
      end else if (tmo == 16'(TIMEOUT_CYCLES)) begin
        state_nxt = RESP;
        code_nxt  = C_TIMEOUT;
        flush     = 1'b1;
      end else tmo_nxt = tmo + 16'd1;
      WAIT_CMPL: if (llkid_key_complete) begin
        state_nxt = RESP;
        code_nxt  = C_LOAD_OK;
      end else if (tmo == 16'(TIMEOUT_CYCLES)) begin
        state_nxt = RESP;
        code_nxt  = C_TIMEOUT;
      end else tmo_nxt = tmo + 16'd1;
      CLEAR: if (llkid_clear_key_ack) begin
        state_nxt = RESP;
        code_nxt  = C_CLEAR_OK;
      end else if (tmo == 16'(TIMEOUT_CYCLES)) begin
        state_nxt = RESP;
        code_nxt  = C_TIMEOUT;
      end else tmo_nxt = tmo + 16'd1;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    llkid_key_valid = (state == SEND);
    llkid_key_data  = llkid_key_valid ? mem[rd_ptr] : 64'd0;
    llkid_clear_key = (state == CLEAR);
    rsp_valid       = (state == RESP);
    cmd_ready       = started & (state == IDLE);
    busy            = (state != IDLE);
  end

endmodule
